// File: rtl/bambu_mem_responder.sv
// Dual-channel RAM slave for the Bambu minimal-memory master interface.
// Fixed read/write latencies; out-of-window requests are left to other slaves.
module bambu_mem_responder #(
    parameter int MEMSIZE     = 32,
    parameter int BASE_ADDR   = 0,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Mout_oe_ram,
    input  logic [1:0]  Mout_we_ram,
    input  logic [13:0] Mout_addr_ram,
    input  logic [15:0] Mout_Wdata_ram,
    input  logic [7:0]  Mout_data_ram_size,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic        proto_err
);

    localparam int AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [7:0] LO = 8'(BASE_ADDR);
    localparam logic [7:0] HI = 8'(BASE_ADDR + MEMSIZE);
    localparam logic [3:0] RDL = 4'(READ_DELAY - 1);
    localparam logic [3:0] WRL = 4'(WRITE_DELAY - 1);

    logic [7:0] mem [0:(1<<AW)-1];

    logic [1:0][3:0]    cnt;
    logic [1:0][7:0]    rd_q;
    logic               err_q;

    logic [1:0]         act, rd_done, wr_done, done, both;
    logic [1:0][7:0]    addr8, wdata, mask;
    logic [1:0][3:0]    size;
    logic [1:0][AW-1:0] idx;

    always_comb begin
        act     = '0;
        rd_done = '0;
        wr_done = '0;
        both    = '0;
        addr8   = '0;
        wdata   = '0;
        mask    = '0;
        size    = '0;
        idx     = '0;
        for (int c = 0; c < 2; c++) begin
            addr8[c] = {1'b0, Mout_addr_ram[c*7 +: 7]};
            wdata[c] = Mout_Wdata_ram[c*8 +: 8];
            size[c]  = Mout_data_ram_size[c*4 +: 4];
            idx[c]   = AW'(addr8[c] - LO);
            mask[c]  = (size[c] >= 4'd8) ? 8'hFF
                     : 8'((9'd1 << size[c]) - 9'd1);
            both[c]  = Mout_oe_ram[c] & Mout_we_ram[c];
            // reset also gates activity so nothing completes or commits in reset
            act[c]   = reset & (Mout_oe_ram[c] ^ Mout_we_ram[c])
                     & (addr8[c] >= LO) & (addr8[c] < HI);
            rd_done[c] = act[c] & Mout_oe_ram[c] & (cnt[c] == RDL);
            wr_done[c] = act[c] & Mout_we_ram[c] & (cnt[c] == WRL);
        end
        done = rd_done | wr_done;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt   <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                cnt[c]  <= (act[c] && !done[c]) ? cnt[c] + 4'd1 : 4'd0;
                rd_q[c] <= (act[c] && Mout_oe_ram[c]) ? mem[idx[c]] : 8'd0;
            end
            if (|both)
                err_q <= 1'b1;
        end
    end

    // ch1 is applied last so it wins a same-offset collision
    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_done[c])
                mem[idx[c]] <= (wdata[c] & mask[c])
                             | (mem[idx[c]] & ~mask[c]);
        end
    end

    always_comb begin
        Sout_Rdata_ram = '0;
        for (int c = 0; c < 2; c++)
            Sout_Rdata_ram[c*8 +: 8] = rd_done[c] ? rd_q[c] : 8'd0;
    end

    assign Sout_DataRdy = done;
    assign proto_err    = err_q;

endmodule

// File: tb/tb_bambu_mem_responder.sv
// Scoreboard bench for bambu_mem_responder (BASE_ADDR=16, MEMSIZE=32,
// READ_DELAY=2, WRITE_DELAY=1).
module tb_bambu_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  oe = '0, we = '0;
    logic [13:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [7:0]  size = '0;
    logic [15:0] rdata;
    logic [1:0]  rdy;
    logic        perr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    bambu_mem_responder #(
        .MEMSIZE(32), .BASE_ADDR(16), .READ_DELAY(2), .WRITE_DELAY(1)
    ) dut (
        .clock(clk), .reset(rst_n),
        .Mout_oe_ram(oe), .Mout_we_ram(we),
        .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
        .Mout_data_ram_size(size),
        .Sout_Rdata_ram(rdata), .Sout_DataRdy(rdy),
        .proto_err(perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Monitor: every completion is matched against the scoreboard
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            logic [7:0] got;
            exp_t e;
            got = rdata[c*8 +: 8];
            if (rdy[c]) begin
                checks++;
                if ((c == 0 ? q0.size() : q1.size()) == 0) begin
                    errors++;
                    $display("FAIL unexpected_rdy ch%0d cycle %0d data %h",
                             c, cyc, got);
                end else begin
                    e = (c == 0) ? q0.pop_front() : q1.pop_front();
                    if (got !== e.d || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL resp ch%0d got data %h cycle %0d, want %h cycle %0d",
                                 c, got, cyc, e.d, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (got !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_rdata ch%0d got %h want 00", c, got);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic o, input logic w,
                          input logic [6:0] a, input logic [7:0] d,
                          input logic [3:0] s);
        oe[c]           = o;
        we[c]           = w;
        addr[c*7 +: 7]  = a;
        wdata[c*8 +: 8] = d;
        size[c*4 +: 4]  = s;
    endtask

    task automatic push(input int c, input logic [7:0] d, input int at);
        exp_t e;
        e.d   = d;
        e.cyc = at;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wr(input int c, input logic [6:0] a,
                      input logic [7:0] d, input logic [3:0] s);
        set_ch(c, 1'b0, 1'b1, a, d, s);
        push(c, 8'h00, cyc);
        step();
        set_ch(c, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();
    endtask

    task automatic rd(input int c, input logic [6:0] a, input logic [7:0] d);
        set_ch(c, 1'b1, 1'b0, a, 8'd0, 4'd8);
        push(c, d, cyc + 1);
        step();
        step();
        set_ch(c, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_perr", 32'(perr), 32'h0);
        rst_n = 1'b1;
        step();

        // basic write then read
        wr(0, 7'd19, 8'hA5, 4'd8);
        rd(0, 7'd19, 8'hA5);

        // partial and zero-size writes
        wr(1, 7'd20, 8'hFF, 4'd8);
        wr(1, 7'd20, 8'h00, 4'd4);
        rd(1, 7'd20, 8'hF0);
        wr(1, 7'd20, 8'h00, 4'd0);
        rd(1, 7'd20, 8'hF0);

        // boundary offsets of the window
        wr(0, 7'd16, 8'h5C, 4'd8);
        wr(1, 7'd47, 8'hC3, 4'd9);
        rd(1, 7'd16, 8'h5C);
        rd(0, 7'd47, 8'hC3);

        // read on ch0 at the same edge ch1 commits a write
        wr(0, 7'd21, 8'h77, 4'd8);
        set_ch(0, 1'b1, 1'b0, 7'd21, 8'd0, 4'd8);
        set_ch(1, 1'b0, 1'b1, 7'd21, 8'h3C, 4'd8);
        push(1, 8'h00, cyc);
        push(0, 8'h77, cyc + 1);
        step();
        set_ch(1, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();
        set_ch(0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();
        rd(0, 7'd21, 8'h3C);

        // simultaneous writes to one offset: ch1 wins
        set_ch(0, 1'b0, 1'b1, 7'd22, 8'h11, 4'd8);
        set_ch(1, 1'b0, 1'b1, 7'd22, 8'h22, 4'd8);
        push(0, 8'h00, cyc);
        push(1, 8'h00, cyc);
        step();
        set_ch(0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        set_ch(1, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();
        rd(1, 7'd22, 8'h22);

        // back-to-back reads held high
        set_ch(0, 1'b1, 1'b0, 7'd19, 8'd0, 4'd8);
        push(0, 8'hA5, cyc + 1);
        push(0, 8'hA5, cyc + 3);
        repeat (4) step();
        set_ch(0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();

        // out of window above and below
        set_ch(0, 1'b1, 1'b0, 7'd48, 8'd0, 4'd8);
        set_ch(1, 1'b1, 1'b0, 7'd15, 8'd0, 4'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("oow_rdy", 32'(rdy), 32'h0);
            chk("oow_rdata", 32'(rdata), 32'h0);
            step();
        end
        set_ch(0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        set_ch(1, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();

        // abort after one cycle, then full-latency read
        set_ch(0, 1'b1, 1'b0, 7'd19, 8'd0, 4'd8);
        step();
        set_ch(0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        step();
        rd(0, 7'd19, 8'hA5);

        // reset in the commit cycle of a write
        set_ch(0, 1'b0, 1'b1, 7'd19, 8'h5A, 4'd8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_commit_rdy", 32'(rdy), 32'h0);
        chk("rst_commit_rdata", 32'(rdata), 32'h0);
        step();
        set_ch(0, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        rst_n = 1'b1;
        step();
        rd(0, 7'd19, 8'hA5);

        // protocol error on ch1
        set_ch(1, 1'b1, 1'b1, 7'd20, 8'h99, 4'd8);
        @(negedge clk);
        chk("perr_rdy1", 32'(rdy[1]), 32'h0);
        step();
        set_ch(1, 1'b0, 1'b0, 7'd0, 8'd0, 4'd0);
        @(negedge clk);
        chk("perr_set", 32'(perr), 32'h1);
        repeat (3) step();
        @(negedge clk);
        chk("perr_sticky", 32'(perr), 32'h1);
        rd(1, 7'd20, 8'hF0);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("perr_cleared", 32'(perr), 32'h0);
        rst_n = 1'b1;
        step();
        step();

        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
